turing_core: RTL and testbench

- Parametrised successor to the single-bit Turing machine: multi-bit symbols, configurable state count, tape length and display window.
- Holds a writable transition table and tape in register arrays. Executes transitions free-running or single-step, with halt, boundary-fault and step-limit termination.
- Sits between the board I/O front end (program/tape loaders, buttons) and the tape display driver.

---
 rtl/turing_core.sv | 155 +++++++++++++++
 tb/tb_turing_core.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/turing_core.sv
// Parametrised Turing machine core: writable transition table and tape held in
// register arrays, free-running or single-step execution, windowed tape output.
module turing_core #(
  parameter int unsigned SYM_W    = 2,
  parameter int unsigned ST_W     = 3,
  parameter int unsigned TAPE_LEN = 32,
  parameter int unsigned WIN      = 11,
  parameter int unsigned CNT_W    = 16,
  localparam int unsigned AW      = $clog2(TAPE_LEN)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  prog_we,
  input  logic [ST_W+SYM_W-1:0] prog_addr,
  input  logic [SYM_W+ST_W+1:0] prog_data,
  input  logic                  tape_we,
  input  logic [AW-1:0]         tape_addr,
  input  logic [SYM_W-1:0]      tape_data,
  input  logic [AW-1:0]         head_init,
  input  logic                  start,
  input  logic                  step_mode,
  input  logic                  step,
  input  logic [CNT_W-1:0]      max_steps,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            status,
  output logic [ST_W-1:0]       cur_state,
  output logic [AW-1:0]         head_pos,
  output logic [CNT_W-1:0]      step_count,
  output logic [WIN*SYM_W-1:0]  window
);

  localparam int unsigned ENT_W = SYM_W + 2 + ST_W;
  localparam int unsigned TBL_N = 1 << (ST_W + SYM_W);
  localparam int unsigned HALF  = WIN / 2;

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, DONE} fsm_t;
  typedef enum logic [1:0] {MV_L = 2'b00, MV_R = 2'b01, MV_STAY = 2'b10, MV_HALT = 2'b11} move_t;
  typedef enum logic [1:0] {ST_NONE = 2'b00, ST_HALT = 2'b01, ST_FAULT = 2'b10, ST_TIMEOUT = 2'b11} status_t;

  fsm_t              fsm;
  logic              step_mode_r;
  logic [SYM_W-1:0]  sym;

  logic [ENT_W-1:0]  prog_table [TBL_N];
  logic [SYM_W-1:0]  tape [TAPE_LEN];

  logic [ENT_W-1:0]  entry;
  logic [SYM_W-1:0]  write_sym;
  move_t             move;
  logic [ST_W-1:0]   next_state;
  logic [CNT_W-1:0]  next_count;
  logic [AW-1:0]     moved_head;
  logic              at_edge;
  logic [31:0]       pos;

  always_comb begin
    entry      = prog_table[{cur_state, sym}];
    next_state = entry[ST_W-1:0];
    move       = move_t'(entry[ST_W+1:ST_W]);
    write_sym  = entry[ST_W+2 +: SYM_W];
    next_count = (step_count == '1) ? step_count : step_count + CNT_W'(1);
    at_edge    = (move == MV_L && head_pos == '0) ||
                 (move == MV_R && head_pos == AW'(TAPE_LEN - 1));
    case (move)
      MV_L:    moved_head = head_pos - AW'(1);
      MV_R:    moved_head = head_pos + AW'(1);
      default: moved_head = head_pos;
    endcase
  end

  // Storage arrays are deliberately outside reset so loaded programs survive an abort.
  always_ff @(posedge clock) begin
    if (prog_we && !busy)
      prog_table[prog_addr] <= prog_data;
    if (tape_we && !busy)
      tape[tape_addr] <= tape_data;
    else if (fsm == EXEC)
      tape[head_pos] <= write_sym;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fsm         <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      status      <= ST_NONE;
      cur_state   <= '0;
      head_pos    <= '0;
      step_count  <= '0;
      step_mode_r <= 1'b0;
      sym         <= '0;
    end else begin
      case (fsm)
        IDLE, DONE: begin
          if (start) begin
            head_pos    <= head_init;
            step_mode_r <= step_mode;
            cur_state   <= '0;
            step_count  <= '0;
            status      <= ST_NONE;
            done        <= 1'b0;
            busy        <= 1'b1;
            fsm         <= FETCH;
          end
        end
        FETCH: begin
          if (!step_mode_r || step) begin
            sym <= tape[head_pos];
            fsm <= EXEC;
          end
        end
        EXEC: begin
          cur_state  <= next_state;
          step_count <= next_count;
          // Halt outranks a boundary fault, which outranks the step limit.
          if (move == MV_HALT) begin
            status <= ST_HALT;
            busy   <= 1'b0;
            done   <= 1'b1;
            fsm    <= DONE;
          end else if (at_edge) begin
            status <= ST_FAULT;
            busy   <= 1'b0;
            done   <= 1'b1;
            fsm    <= DONE;
          end else begin
            head_pos <= moved_head;
            if (max_steps != '0 && next_count == max_steps) begin
              status <= ST_TIMEOUT;
              busy   <= 1'b0;
              done   <= 1'b1;
              fsm    <= DONE;
            end else begin
              fsm <= FETCH;
            end
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

  // Slot i shows cell head_pos - HALF + i; offsetting by HALF keeps the math unsigned.
  always_comb begin
    window = '0;
    pos    = '0;
    for (int unsigned i = 0; i < WIN; i++) begin
      pos = 32'(head_pos) + i;
      if (pos >= HALF && (pos - HALF) < TAPE_LEN)
        window[i*SYM_W +: SYM_W] = tape[AW'(pos - HALF)];
    end
  end

endmodule

// File: tb/tb_turing_core.sv
// Scoreboard bench for turing_core: stimulus queues expected snapshots, a
// negedge monitor pops and compares them on done rising or on a snapshot request.
module tb_turing_core;

  localparam int unsigned SYM_W    = 2;
  localparam int unsigned ST_W     = 3;
  localparam int unsigned TAPE_LEN = 32;
  localparam int unsigned WIN      = 11;
  localparam int unsigned CNT_W    = 16;
  localparam int unsigned AW       = 5;

  localparam logic [1:0] L = 2'b00, R = 2'b01, S = 2'b10, H = 2'b11;

  logic                  clock = 1'b0;
  logic                  reset = 1'b1;
  logic                  prog_we = 1'b0;
  logic [ST_W+SYM_W-1:0] prog_addr = '0;
  logic [SYM_W+ST_W+1:0] prog_data = '0;
  logic                  tape_we = 1'b0;
  logic [AW-1:0]         tape_addr = '0;
  logic [SYM_W-1:0]      tape_data = '0;
  logic [AW-1:0]         head_init = '0;
  logic                  start = 1'b0;
  logic                  step_mode = 1'b0;
  logic                  step = 1'b0;
  logic [CNT_W-1:0]      max_steps = '0;
  logic                  busy;
  logic                  done;
  logic [1:0]            status;
  logic [ST_W-1:0]       cur_state;
  logic [AW-1:0]         head_pos;
  logic [CNT_W-1:0]      step_count;
  logic [WIN*SYM_W-1:0]  window;

  turing_core #(
    .SYM_W(SYM_W), .ST_W(ST_W), .TAPE_LEN(TAPE_LEN), .WIN(WIN), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .reset(reset),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .tape_we(tape_we), .tape_addr(tape_addr), .tape_data(tape_data),
    .head_init(head_init), .start(start), .step_mode(step_mode), .step(step),
    .max_steps(max_steps), .busy(busy), .done(done), .status(status),
    .cur_state(cur_state), .head_pos(head_pos), .step_count(step_count),
    .window(window)
  );

  always #5 clock = ~clock;

  typedef struct {
    string                 name;
    logic                  busy;
    logic                  done;
    logic [1:0]            status;
    logic [ST_W-1:0]       state;
    logic [AW-1:0]         head;
    logic [CNT_W-1:0]      count;
    logic [WIN*SYM_W-1:0]  win;
    logic [WIN-1:0]        wmask;
    int unsigned           lat;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  exp_t        x;
  int unsigned checks = 0;
  int unsigned errors = 0;
  logic        snap_req = 1'b0;
  int unsigned run_cyc = 0;
  logic        busy_q = 1'b0;
  logic        done_q = 1'b0;
  logic [WIN*SYM_W-1:0] m;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  // Monitor: compares DUT outputs against the next queued expectation.
  always @(negedge clock) begin
    if (busy && !busy_q) run_cyc = 1;
    else if (busy) run_cyc++;
    if ((done && !done_q) || snap_req) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got done=%0b snap=%0b, required no event", done, snap_req);
      end else begin
        x = q.pop_front();
        chk({x.name, ".busy"},   64'(busy),       64'(x.busy));
        chk({x.name, ".done"},   64'(done),       64'(x.done));
        chk({x.name, ".status"}, 64'(status),     64'(x.status));
        chk({x.name, ".state"},  64'(cur_state),  64'(x.state));
        chk({x.name, ".head"},   64'(head_pos),   64'(x.head));
        chk({x.name, ".count"},  64'(step_count), 64'(x.count));
        if (x.wmask != '0) begin
          m = '0;
          for (int unsigned i = 0; i < WIN; i++)
            if (x.wmask[i]) m[i*SYM_W +: SYM_W] = '1;
          chk({x.name, ".window"}, 64'(window & m), 64'(x.win & m));
        end
        if (x.lat != 0)
          chk({x.name, ".latency"}, 64'(run_cyc), 64'(x.lat));
      end
    end
    busy_q = busy;
    done_q = done;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic prog(input int unsigned st, input int unsigned sy, input int unsigned ws,
                      input logic [1:0] mv, input int unsigned ns);
    prog_we   = 1'b1;
    prog_addr = {ST_W'(st), SYM_W'(sy)};
    prog_data = {SYM_W'(ws), mv, ST_W'(ns)};
    tick();
    prog_we   = 1'b0;
  endtask

  task automatic tape_w(input int unsigned a, input int unsigned d);
    tape_we   = 1'b1;
    tape_addr = AW'(a);
    tape_data = SYM_W'(d);
    tick();
    tape_we   = 1'b0;
  endtask

  task automatic run(input int unsigned hi, input logic sm, input int unsigned ms);
    head_init = AW'(hi);
    step_mode = sm;
    max_steps = CNT_W'(ms);
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic snap();
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
  endtask

  task automatic new_exp(input string nm, input logic b, input logic d, input logic [1:0] st,
                         input int unsigned cs, input int unsigned hd, input int unsigned cnt,
                         input int unsigned lat);
    e.name   = nm;
    e.busy   = b;
    e.done   = d;
    e.status = st;
    e.state  = ST_W'(cs);
    e.head   = AW'(hd);
    e.count  = CNT_W'(cnt);
    e.win    = '0;
    e.wmask  = '0;
    e.lat    = lat;
  endtask

  task automatic slot(input int unsigned i, input int unsigned v);
    e.win[i*SYM_W +: SYM_W] = SYM_W'(v);
    e.wmask[i] = 1'b1;
  endtask

  task automatic wait_done(input int unsigned limit);
    int unsigned n = 0;
    while (!done && n < limit) begin
      tick();
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL wait_done: done=0 after %0d cycles, required 1", limit);
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Power-on reset state
    repeat (2) tick();
    reset = 1'b0;
    new_exp("reset", 1'b0, 1'b0, 2'b00, 0, 0, 0, 0);
    q.push_back(e);
    snap();

    // Reset in the middle of a free run (head 5, three steps completed)
    prog(0, 0, 0, S, 0);
    tape_w(4, 3);
    tape_w(5, 0);
    run(5, 1'b0, 0);
    repeat (6) tick();
    new_exp("midrun", 1'b1, 1'b0, 2'b00, 0, 5, 3, 0);
    q.push_back(e);
    snap();
    reset = 1'b1;
    new_exp("midrun_reset", 1'b0, 1'b0, 2'b00, 0, 0, 0, 0);
    slot(9, 3);
    slot(10, 0);
    q.push_back(e);
    snap();
    reset = 1'b0;

    // Unary incrementer; max_steps equals the halting step so halt must win
    prog(0, 1, 1, R, 0);
    prog(0, 0, 1, H, 0);
    tape_w(0, 1);
    tape_w(1, 1);
    tape_w(2, 1);
    tape_w(3, 0);
    new_exp("incr", 1'b0, 1'b1, 2'b01, 0, 3, 4, 8);
    slot(0, 0); slot(1, 0);
    for (int unsigned i = 2; i <= 5; i++) slot(i, 1);
    slot(6, 3); slot(7, 0);
    q.push_back(e);
    run(0, 1'b0, 4);
    wait_done(40);

    // Right boundary fault at the last cell
    prog(0, 0, 2, R, 1);
    tape_w(31, 0);
    new_exp("bound", 1'b0, 1'b1, 2'b10, 1, 31, 1, 2);
    slot(5, 2);
    for (int unsigned i = 6; i < WIN; i++) slot(i, 0);
    q.push_back(e);
    run(31, 1'b0, 0);
    wait_done(20);

    // Step limit on a stay loop
    prog(0, 0, 0, S, 0);
    tape_w(10, 0);
    new_exp("timeout", 1'b0, 1'b1, 2'b11, 0, 10, 5, 10);
    slot(0, 0); slot(5, 0);
    q.push_back(e);
    run(10, 1'b0, 5);
    wait_done(40);

    // Step limit of one: the head still moves
    prog(0, 0, 3, R, 2);
    tape_w(20, 0);
    new_exp("timeout_move", 1'b0, 1'b1, 2'b11, 2, 21, 1, 2);
    slot(4, 3);
    q.push_back(e);
    run(20, 1'b0, 1);
    wait_done(20);

    // Single-step mode, plus a tape write attempted while busy
    prog(0, 0, 0, S, 0);
    tape_w(10, 0);
    tape_w(12, 2);
    run(10, 1'b1, 0);
    repeat (20) tick();
    new_exp("step_hold", 1'b1, 1'b0, 2'b00, 0, 10, 0, 0);
    q.push_back(e);
    snap();
    for (int k = 0; k < 3; k++) begin
      step = 1'b1;
      tick();
      step = 1'b0;
      tick();
      tick();
    end
    tape_w(12, 3);
    new_exp("step3", 1'b1, 1'b0, 2'b00, 0, 10, 3, 0);
    slot(5, 0); slot(7, 2);
    q.push_back(e);
    snap();
    reset = 1'b1;
    tick();
    reset = 1'b0;

    // Window around head 1, then an idle load showing through
    for (int unsigned i = 0; i < 7; i++) tape_w(i, (i % 3) + 1);
    prog(0, 2, 2, H, 0);
    new_exp("window", 1'b0, 1'b1, 2'b01, 0, 1, 1, 2);
    for (int unsigned i = 0; i < 4; i++) slot(i, 0);
    for (int unsigned i = 0; i < 7; i++) slot(i + 4, (i % 3) + 1);
    q.push_back(e);
    run(1, 1'b0, 0);
    wait_done(20);
    tape_w(2, 0);
    new_exp("window_load", 1'b0, 1'b1, 2'b01, 0, 1, 1, 0);
    for (int unsigned i = 0; i < 7; i++) slot(i + 4, (i == 2) ? 0 : (i % 3) + 1);
    q.push_back(e);
    snap();

    tick();
    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
